// File: rtl/dooz_auto_player.sv
// Automatic Dooz (tic-tac-toe) opponent: snapshots the board on its turn, scans for a
// winning line, then a blocking line, then falls back to a fixed cell preference order.
module dooz_auto_player #(
  parameter int THINK_DELAY = 0,
  parameter int USE_BLOCK   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       my_turn,
  input  logic [8:0] own_board,
  input  logic [8:0] opp_board,
  output logic [3:0] move,
  output logic       move_valid,
  output logic       busy,
  output logic       no_move
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN_WIN   = 3'd1,
    SCAN_BLOCK = 3'd2,
    PICK       = 3'd3,
    WAIT       = 3'd4,
    HOLD       = 3'd5
  } state_t;

  localparam logic        DELAYED      = (THINK_DELAY > 0) ? 1'b1 : 1'b0;
  localparam state_t      CHOSEN_STATE = DELAYED ? WAIT : HOLD;
  localparam logic [15:0] WAIT_LAST    = 16'((THINK_DELAY > 0) ? (THINK_DELAY - 1) : 0);

  // Three cell numbers (1..9) of line ln, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] ln);
    case (ln)
      3'd0:    line_cells = {4'd1, 4'd2, 4'd3};
      3'd1:    line_cells = {4'd4, 4'd5, 4'd6};
      3'd2:    line_cells = {4'd7, 4'd8, 4'd9};
      3'd3:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd4:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd5:    line_cells = {4'd3, 4'd6, 4'd9};
      3'd6:    line_cells = {4'd1, 4'd5, 4'd9};
      default: line_cells = {4'd3, 4'd5, 4'd7};
    endcase
  endfunction

  // Empty cell completing two of 'mine' on line ln, or 0 when the line is not a hit.
  function automatic logic [3:0] line_hit(input logic [8:0] mine, input logic [8:0] occ,
                                          input logic [2:0] ln);
    logic [11:0] c;
    logic [3:0]  a, b, d;
    logic        ma, mb, md, ea, eb, ed;
    c  = line_cells(ln);
    a  = c[11:8];
    b  = c[7:4];
    d  = c[3:0];
    ma = mine[a - 4'd1];
    mb = mine[b - 4'd1];
    md = mine[d - 4'd1];
    ea = ~occ[a - 4'd1];
    eb = ~occ[b - 4'd1];
    ed = ~occ[d - 4'd1];
    if (mb && md && ea)      line_hit = a;
    else if (ma && md && eb) line_hit = b;
    else if (ma && mb && ed) line_hit = d;
    else                     line_hit = 4'd0;
  endfunction

  // First empty cell in preference order 5,1,3,7,9,2,4,6,8; 0 when the board is full.
  function automatic logic [3:0] pick_cell(input logic [8:0] occ);
    if (!occ[4])      pick_cell = 4'd5;
    else if (!occ[0]) pick_cell = 4'd1;
    else if (!occ[2]) pick_cell = 4'd3;
    else if (!occ[6]) pick_cell = 4'd7;
    else if (!occ[8]) pick_cell = 4'd9;
    else if (!occ[1]) pick_cell = 4'd2;
    else if (!occ[3]) pick_cell = 4'd4;
    else if (!occ[5]) pick_cell = 4'd6;
    else if (!occ[7]) pick_cell = 4'd8;
    else              pick_cell = 4'd0;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  line_q, line_d;
  logic [8:0]  own_q, own_d, opp_q, opp_d;
  logic [3:0]  move_q, move_d;
  logic        move_valid_q, move_valid_d;
  logic        busy_q, busy_d;
  logic        no_move_q, no_move_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  occ_s;
  logic [3:0]  win_cell_s, blk_cell_s, pick_cell_s;

  assign occ_s       = own_q | opp_q;
  assign win_cell_s  = line_hit(own_q, occ_s, line_q);
  assign blk_cell_s  = line_hit(opp_q, occ_s, line_q);
  assign pick_cell_s = pick_cell(occ_s);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    own_d        = own_q;
    opp_d        = opp_q;
    move_d       = move_q;
    move_valid_d = move_valid_q;
    busy_d       = busy_q;
    no_move_d    = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        move_valid_d = 1'b0;
        busy_d       = 1'b0;
        if (my_turn) begin
          own_d   = own_board;
          opp_d   = opp_board;
          line_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = SCAN_WIN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN_WIN, SCAN_BLOCK: begin
        if (!my_turn) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if ((state_q == SCAN_WIN) && (win_cell_s != 4'd0)) begin
          move_d       = win_cell_s;
          cnt_d        = 16'd0;
          move_valid_d = ~DELAYED;
          busy_d       = DELAYED;
          state_d      = CHOSEN_STATE;
        end else if ((state_q == SCAN_BLOCK) && (blk_cell_s != 4'd0)) begin
          move_d       = blk_cell_s;
          cnt_d        = 16'd0;
          move_valid_d = ~DELAYED;
          busy_d       = DELAYED;
          state_d      = CHOSEN_STATE;
        end else if (line_q == 3'd7) begin
          line_d  = 3'd0;
          state_d = ((state_q == SCAN_WIN) && (USE_BLOCK != 0)) ? SCAN_BLOCK : PICK;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
      PICK: begin
        if (!my_turn) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (pick_cell_s != 4'd0) begin
          move_d       = pick_cell_s;
          cnt_d        = 16'd0;
          move_valid_d = ~DELAYED;
          busy_d       = DELAYED;
          state_d      = CHOSEN_STATE;
        end else begin
          no_move_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      WAIT: begin
        if (!my_turn) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          move_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        busy_d = 1'b0;
        if (!my_turn) begin
          move_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          move_valid_d = 1'b1;
        end
      end
      default: begin
        move_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_q       <= 3'd0;
      own_q        <= 9'd0;
      opp_q        <= 9'd0;
      move_q       <= 4'd0;
      move_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      no_move_q    <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      own_q        <= own_d;
      opp_q        <= opp_d;
      move_q       <= move_d;
      move_valid_q <= move_valid_d;
      busy_q       <= busy_d;
      no_move_q    <= no_move_d;
      cnt_q        <= cnt_d;
    end
  end

  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign busy       = busy_q;
  assign no_move    = no_move_q;

endmodule

// File: tb/tb_dooz_auto_player.sv
// Scoreboard bench for dooz_auto_player: three instances (default, THINK_DELAY=3, USE_BLOCK=0)
// get directed boards; a negedge monitor pops expected move/no_move events and compares.
module tb_dooz_auto_player;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] turn;
  logic [8:0] own_b, opp_b;
  logic [3:0] mv [3];
  logic [2:0] vld, bsy, nm;

  always #5 clk = ~clk;

  dooz_auto_player #(.THINK_DELAY(0), .USE_BLOCK(1)) dut0 (
    .clk(clk), .reset(reset), .my_turn(turn[0]), .own_board(own_b), .opp_board(opp_b),
    .move(mv[0]), .move_valid(vld[0]), .busy(bsy[0]), .no_move(nm[0]));
  dooz_auto_player #(.THINK_DELAY(3), .USE_BLOCK(1)) dut1 (
    .clk(clk), .reset(reset), .my_turn(turn[1]), .own_board(own_b), .opp_board(opp_b),
    .move(mv[1]), .move_valid(vld[1]), .busy(bsy[1]), .no_move(nm[1]));
  dooz_auto_player #(.THINK_DELAY(0), .USE_BLOCK(0)) dut2 (
    .clk(clk), .reset(reset), .my_turn(turn[2]), .own_board(own_b), .opp_board(opp_b),
    .move(mv[2]), .move_valid(vld[2]), .busy(bsy[2]), .no_move(nm[2]));

  typedef struct {
    int         inst;
    int         kind;   // 1 = move_valid rise, 2 = no_move pulse
    logic [3:0] mv;
    int         at;     // edge count at which the event becomes visible
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mon_kind, mon_idx;
  logic [2:0] prev_vld = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // Monitor: every output event must match the oldest pending expectation for that instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset && nm[i])                       mon_kind = 2;
      else if (reset && vld[i] && !prev_vld[i]) mon_kind = 1;
      else                                      mon_kind = 0;
      if (mon_kind != 0) begin
        mon_idx = -1;
        for (int j = 0; j < sb.size(); j++)
          if (mon_idx < 0 && sb[j].inst == i) mon_idx = j;
        if (mon_idx < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event dut%0d: got kind %0d move %0d at edge %0d, expected none",
                   i, mon_kind, mv[i], cyc);
        end else begin
          check("event_kind", i, mon_kind, sb[mon_idx].kind);
          check("event_move", i, int'(mv[i]), int'(sb[mon_idx].mv));
          check("event_edge", i, cyc, sb[mon_idx].at);
          sb.delete(mon_idx);
        end
      end
      prev_vld[i] <= reset ? vld[i] : 1'b0;
    end
  end

  // mode 0: normal turn, 1: drop turn after edge n (abort), 2: leave turn high in HOLD
  task automatic drive(input int i, input int kind, input logic [3:0] m, input int n,
                       input int mode);
    int   e0;
    exp_t e;
    @(negedge clk);
    turn[i] = 1'b1;
    e0 = cyc + 1;
    if (mode != 1) begin
      e.inst = i;
      e.kind = kind;
      e.mv   = m;
      e.at   = e0 + n;
      sb.push_back(e);
    end
    @(negedge clk);
    check("busy_scan", i, int'(bsy[i]), 1);
    repeat (n) @(negedge clk);
    if (mode == 1) begin
      turn[i] = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_valid", i, int'(vld[i]), 0);
      check("abort_busy", i, int'(bsy[i]), 0);
      check("abort_move", i, int'(mv[i]), int'(m));
    end else if (kind == 2) begin
      turn[i] = 1'b0;
      @(negedge clk);
      check("nomove_single", i, int'(nm[i]), 0);
      check("nomove_valid", i, int'(vld[i]), 0);
      check("nomove_busy", i, int'(bsy[i]), 0);
    end else begin
      @(negedge clk);
      check("hold_valid", i, int'(vld[i]), 1);
      check("hold_busy", i, int'(bsy[i]), 0);
      if (mode == 0) begin
        turn[i] = 1'b0;
        @(negedge clk);
        check("drop_valid", i, int'(vld[i]), 0);
        check("drop_move", i, int'(mv[i]), int'(m));
      end
    end
  endtask

  task automatic run_vec(input logic [8:0] own, input logic [8:0] opp,
                         input int k0, input logic [3:0] m0, input int n0,
                         input int k1, input logic [3:0] m1, input int n1,
                         input int k2, input logic [3:0] m2, input int n2,
                         input int mode);
    own_b = own;
    opp_b = opp;
    fork
      drive(0, k0, m0, n0, mode);
      drive(1, k1, m1, n1, mode);
      drive(2, k2, m2, n2, mode);
    join
  endtask

  initial begin
    reset = 1'b0;
    turn  = 3'b000;
    own_b = 9'd0;
    opp_b = 9'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_move", i, int'(mv[i]), 0);
      check("reset_valid", i, int'(vld[i]), 0);
      check("reset_busy", i, int'(bsy[i]), 0);
      check("reset_nomove", i, int'(nm[i]), 0);
    end
    reset = 1'b1;

    // win on line 0
    run_vec(9'h003, 9'h018, 1, 4'd3, 1,  1, 4'd3, 4,  1, 4'd3, 1, 0);
    // block on line 1; without blocking the preference pick lands on 3
    run_vec(9'h001, 9'h030, 1, 4'd4, 10, 1, 4'd4, 13, 1, 4'd3, 9, 0);
    // empty board picks centre
    run_vec(9'h000, 9'h000, 1, 4'd5, 17, 1, 4'd5, 20, 1, 4'd5, 9, 0);
    // centre taken picks corner 1
    run_vec(9'h000, 9'h010, 1, 4'd1, 17, 1, 4'd1, 20, 1, 4'd1, 9, 0);
    // full board: no_move pulse, move stays 1
    run_vec(9'h0AA, 9'h155, 2, 4'd1, 17, 2, 4'd1, 17, 2, 4'd1, 9, 0);
    // abort after E4: nothing presented, move stays 1
    run_vec(9'h000, 9'h000, 0, 4'd1, 4,  0, 4'd1, 4,  0, 4'd1, 4, 1);
    // fresh scan from line 0: win on line 7
    run_vec(9'h014, 9'h001, 1, 4'd7, 8,  1, 4'd7, 11, 1, 4'd7, 8, 0);
    // win on line 2 beats block on line 0; left holding for the reset test
    run_vec(9'h0C0, 9'h003, 1, 4'd9, 3,  1, 4'd9, 6,  1, 4'd9, 3, 2);

    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("midreset_move", i, int'(mv[i]), 0);
      check("midreset_valid", i, int'(vld[i]), 0);
      check("midreset_busy", i, int'(bsy[i]), 0);
    end
    turn = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event dut%0d: got nothing, expected kind %0d move %0d at edge %0d",
               sb[0].inst, sb[0].kind, sb[0].mv, sb[0].at);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
